// File: rtl/uart_loader.sv
// UART-driven RAM loader: receives 8N1 bytes, takes a 14-bit word count, then writes N little-endian
// words to the RAM upgrade port. Defining CHECKSUM_EN adds a trailing XOR checksum byte.
module uart_loader #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic        upg_clk_i,
  input  logic        upg_rstn_i,
  input  logic        rx_i,
  output logic        upg_wen_o,
  output logic [13:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        upg_err_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CHK, DONE} ld_state_e;
  localparam ld_state_e LdAfterData = CHK;
`else
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, DONE} ld_state_e;
  localparam ld_state_e LdAfterData = DONE;
`endif

  // Synchronizer plus one extra flop for falling-edge detection; all idle high.
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
    if (!upg_rstn_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  rx_state_e       rx_state_q;
  logic [CntW-1:0] clk_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic [7:0]      rx_byte_q;
  logic            byte_valid_q;
  logic            frame_err_q;

  // A framing error returns to RX_IDLE with the line possibly still low; the edge detector then
  // waits for the line to go high before a new start bit can be seen.
  always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
    if (!upg_rstn_i) begin
      rx_state_q   <= RX_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      unique case (rx_state_q)
        RX_IDLE: begin
          clk_cnt_q <= '0;
          if (rx_prev_q && !rx_sync_q) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (clk_cnt_q == HalfLast) begin
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt_q == BitLast) begin
            clk_cnt_q <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt_q == BitLast) begin
            clk_cnt_q  <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_sync_q) begin
              rx_byte_q    <= shift_q;
              byte_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  ld_state_e   ld_state_q;
  logic [13:0] words_q;
  logic [13:0] adr_q;
  logic [1:0]  byte_idx_q;
  logic [31:0] word_q;
  logic [31:0] dat_q;
  logic        wen_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] word_next;
`ifdef CHECKSUM_EN
  logic [7:0]  xor_q;
`endif

  assign word_next = {rx_byte_q, word_q[31:8]};

  // done_q trails the DONE state by a cycle so the final strobe never overlaps done.
  always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
    if (!upg_rstn_i) begin
      ld_state_q <= LEN_LO;
      words_q    <= '0;
      adr_q      <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      dat_q      <= '0;
      wen_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      wen_q <= 1'b0;
      if (wen_q) adr_q <= adr_q + 14'd1;
      if (ld_state_q == DONE) done_q <= 1'b1;
      if (frame_err_q && ld_state_q != DONE) err_q <= 1'b1;
      if (byte_valid_q) begin
        unique case (ld_state_q)
          LEN_LO: begin
            words_q[7:0] <= rx_byte_q;
            ld_state_q   <= LEN_HI;
          end
          LEN_HI: begin
            words_q[13:8] <= rx_byte_q[5:0];
            ld_state_q    <= ({rx_byte_q[5:0], words_q[7:0]} == 14'd0) ? LdAfterData : DATA;
          end
          DATA: begin
            word_q     <= word_next;
            byte_idx_q <= byte_idx_q + 2'd1;
`ifdef CHECKSUM_EN
            xor_q      <= xor_q ^ rx_byte_q;
`endif
            if (byte_idx_q == 2'd3) begin
              wen_q <= 1'b1;
              dat_q <= word_next;
              if (adr_q == words_q - 14'd1) ld_state_q <= LdAfterData;
            end
          end
`ifdef CHECKSUM_EN
          CHK: begin
            if (rx_byte_q != xor_q) err_q <= 1'b1;
            ld_state_q <= DONE;
          end
`endif
          DONE: ;
          default: ld_state_q <= LEN_LO;
        endcase
      end
    end
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign upg_err_o  = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader with a write-strobe scoreboard; compile with +define+CHECKSUM_EN
// to exercise the checksum build.
module tb_uart_loader;

  localparam int unsigned C = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic        wen;
  logic [13:0] adr;
  logic [31:0] dat;
  logic        done;
  logic        err;

  int nvec = 0;
  int nerr = 0;
  int nstrobe = 0;
  logic [45:0] sb[$];
  logic [7:0] seq[$];

  always #5 clk = ~clk;

  uart_loader #(.CLKS_PER_BIT(C)) dut (
    .upg_clk_i (clk),
    .upg_rstn_i(rst_n),
    .rx_i      (rx),
    .upg_wen_o (wen),
    .upg_adr_o (adr),
    .upg_dat_o (dat),
    .upg_done_o(done),
    .upg_err_o (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic [45:0] e;
    logic prev_wen;
    prev_wen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && wen) begin
        nstrobe++;
        e = (sb.size() != 0) ? sb.pop_front() : '1;
        check("strobe_adr", 32'(adr), 32'(e[45:32]));
        check("strobe_dat", dat, e[31:0]);
        check("strobe_done_low", 32'(done), 32'd0);
        check("strobe_one_cycle", 32'(prev_wen), 32'd0);
      end
      prev_wen = rst_n & wen;
    end
  endtask

  task automatic push(input logic [13:0] a, input logic [31:0] d);
    sb.push_back({a, d});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = stop_bit;
    repeat (C) @(negedge clk);
    rx = 1'b1;
    repeat (C) @(negedge clk);
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i], 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int s0;
    rx = 1'b1;
    rst_n = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check("rst_wen", 32'(wen), 32'd0);
    check("rst_adr", 32'(adr), 32'd0);
    check("rst_dat", dat, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Two-word load
    push(14'd0, 32'h1234_5678);
    push(14'd1, 32'hDEAD_BEEF);
    seq = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD};
    send_seq();
    check("two_word_not_done", 32'(done), 32'd0);
    send_byte(8'hDE, 1'b1);
`ifdef CHECKSUM_EN
    check("two_word_chk_wait", 32'(done), 32'd0);
    send_byte(8'h2A, 1'b1);
`endif
    repeat (4) @(negedge clk);
    check("two_word_done", 32'(done), 32'd1);
    check("two_word_err", 32'(err), 32'd0);
    check("two_word_strobes", 32'(nstrobe), 32'd2);
    check("two_word_sb_empty", 32'(sb.size()), 32'd0);
    check("two_word_adr", 32'(adr), 32'd2);

    // Bytes after done are ignored
    for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), 1'b1);
    repeat (4) @(negedge clk);
    check("post_done_strobes", 32'(nstrobe), 32'd2);
    check("post_done_adr", 32'(adr), 32'd2);
    check("post_done_done", 32'(done), 32'd1);
    check("post_done_err", 32'(err), 32'd0);

    // Zero-length load
    do_reset();
    check("zero_after_rst_done", 32'(done), 32'd0);
    s0 = nstrobe;
    send_byte(8'h00, 1'b1);
    check("zero_byte0_done", 32'(done), 32'd0);
    send_byte(8'h00, 1'b1);
`ifdef CHECKSUM_EN
    check("zero_chk_wait", 32'(done), 32'd0);
    send_byte(8'h00, 1'b1);
`endif
    check("zero_done", 32'(done), 32'd1);
    check("zero_err", 32'(err), 32'd0);
    check("zero_strobes", 32'(nstrobe - s0), 32'd0);

    // Glitch rejection and framing error
    do_reset();
    s0 = nstrobe;
    rx = 1'b0;
    repeat (C / 4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * C) @(negedge clk);
    check("glitch_err", 32'(err), 32'd0);
    send_byte(8'h05, 1'b0);
    check("frame_err", 32'(err), 32'd1);
    check("frame_done", 32'(done), 32'd0);
    check("frame_adr", 32'(adr), 32'd0);
    push(14'd0, 32'h4433_2211);
    seq = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_seq();
`ifdef CHECKSUM_EN
    send_byte(8'h44, 1'b1);
`endif
    repeat (4) @(negedge clk);
    check("frame_then_load_done", 32'(done), 32'd1);
    check("frame_then_load_strobes", 32'(nstrobe - s0), 32'd1);
    check("frame_then_load_sb", 32'(sb.size()), 32'd0);

    // Reset mid-word, then a fresh load
    do_reset();
    seq = '{8'h04, 8'h00};
    for (int w = 0; w < 3; w++) begin
      push(14'(w), {4{8'(8'hA0 + w)}});
      for (int b = 0; b < 4; b++) seq.push_back(8'(8'hA0 + w));
    end
    seq.push_back(8'h5A);
    seq.push_back(8'hA5);
    send_seq();
    check("mid_sb_drained", 32'(sb.size()), 32'd0);
    check("mid_adr", 32'(adr), 32'd3);
    repeat (C / 2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_wen", 32'(wen), 32'd0);
    check("async_rst_adr", 32'(adr), 32'd0);
    check("async_rst_dat", dat, 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    push(14'd0, 32'hDDCC_BBAA);
    seq = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_seq();
`ifdef CHECKSUM_EN
    send_byte(8'h00, 1'b1);
`endif
    repeat (4) @(negedge clk);
    check("reload_done", 32'(done), 32'd1);
    check("reload_err", 32'(err), 32'd0);
    check("reload_sb", 32'(sb.size()), 32'd0);

`ifdef CHECKSUM_EN
    // Bad checksum still completes but flags an error
    do_reset();
    push(14'd0, 32'h4433_2211);
    seq = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_seq();
    repeat (4) @(negedge clk);
    check("badchk_done", 32'(done), 32'd1);
    check("badchk_err", 32'(err), 32'd1);
    check("badchk_sb", 32'(sb.size()), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning upg_clk_i cycles per UART bit (10 MHz / 115200).
REQ-002 SHALL have port upg_clk_i, input, 1, the programmer clock (10 MHz).
REQ-003 SHALL have port upg_rstn_i, input, 1, the reset; it is asynchronous and active-low.
REQ-004 SHALL have port rx_i, input, 1, the UART serial line (8N1, idle high).
REQ-005 SHALL have port upg_wen_o, input-side direction output, 1, a one-cycle write strobe to the data RAM.
REQ-006 SHALL have port upg_adr_o, output, 14, the RAM word address.
REQ-007 SHALL have port upg_dat_o, output, 32, the RAM write data.
REQ-008 SHALL have port upg_done_o, output, 1, high once the load is complete.
REQ-009 SHALL have port upg_err_o, output, 1, a sticky flag for a framing or checksum error.

Function
REQ-010 SHALL pass rx_i through a two-flop synchronizer before any use.
REQ-011 Receiver FSM SHALL use the states RX_IDLE, RX_START, RX_DATA and RX_STOP.
REQ-012 Receiver SHALL leave RX_IDLE on a synchronized falling edge.
REQ-013 Receiver SHALL re-sample at CLKS_PER_BIT/2; if the line is high, it SHALL return to RX_IDLE (glitch rejected).
REQ-014 Receiver SHALL sample 8 data bits LSB-first at each full CLKS_PER_BIT interval.
REQ-015 Receiver SHALL sample the stop bit mid-bit; high means a valid byte, raising an internal byte_valid for one cycle.
REQ-016 A low stop bit SHALL discard the byte, set upg_err_o, and return to RX_IDLE after the line is high.
REQ-017 Loader FSM SHALL use the states LEN_LO, LEN_HI, DATA, CHK and DONE.
REQ-018 Loader SHALL take byte 0 as the word count N[7:0] and byte 1 as N[13:8], with bits [7:6] of byte 1 ignored.
REQ-019 In DATA, loader SHALL assemble bytes little-endian into a 32-bit word (first byte goes to [7:0]).
REQ-020 On the 4th byte of each word, loader SHALL pulse upg_wen_o for exactly one cycle, with upg_dat_o the assembled word and upg_adr_o the word index.
REQ-021 upg_wen_o SHALL assert in the cycle after byte_valid of the 4th byte.
REQ-022 upg_adr_o SHALL start at 0 and increment by 1 in the cycle after each write strobe.
REQ-023 upg_adr_o and upg_dat_o SHALL be stable while upg_wen_o is high.
REQ-024 After N words, loader SHALL go to CHK when CHECKSUM_EN is defined, else to DONE.
REQ-025 N=0 SHALL skip DATA entirely; the transition SHALL occur on LEN_HI byte_valid.
REQ-026 A word count of 16384 SHALL NOT be representable; N is in the range 0..16383.
REQ-027 The address SHALL NOT wrap within a load.
REQ-028 In DONE, upg_done_o SHALL be 1 and held until reset.
REQ-029 In DONE, all further bytes SHALL be ignored, with no strobes and no error.
REQ-030 A framing error SHALL NOT advance the loader; the byte is simply missing and the loader keeps waiting.
REQ-031 upg_wen_o SHALL never be asserted while upg_done_o is 1.

Reset
REQ-032 Asserting upg_rstn_i low SHALL asynchronously clear all state, at any time including mid-byte or mid-word.
REQ-033 Reset values SHALL be: upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=0, upg_err_o=0, receiver RX_IDLE, loader LEN_LO, synchronizer flops=1.
REQ-034 After release, the first falling edge on rx_i SHALL be treated as the start of byte 0 of a new load.

Configuration
REQ-035 Macro CHECKSUM_EN SHALL control the checksum feature.
REQ-036 With CHECKSUM_EN defined, the loader SHALL keep a running XOR of every DATA byte.
REQ-037 With CHECKSUM_EN defined, the loader in CHK SHALL accept one byte and compare it with the XOR; on a mismatch it SHALL set upg_err_o.
REQ-038 With CHECKSUM_EN defined, the loader SHALL enter DONE after CHK regardless of the comparison result.
REQ-039 Without CHECKSUM_EN, the CHK state and XOR logic SHALL be absent and upg_err_o SHALL reflect framing errors only.

Verification
REQ-040 Send bytes 02 00 78 56 34 12 EF BE AD DE -> strobe at adr 0 with 0x12345678, strobe at adr 1 with 0xDEADBEEF, then done=1 (CHECKSUM_EN off).
REQ-041 With CHECKSUM_EN, send 01 00 11 22 33 44 44 -> one strobe at adr 0 with 0x44332211, done=1, err=0; a checksum byte of 45 instead -> done=1, err=1.
REQ-042 Send 00 00 -> done=1 after byte 1, no strobe.
REQ-043 Inject a half-bit low glitch on idle rx_i -> no byte is received; insert a byte with stop bit=0 -> err=1, loader state unchanged.
REQ-044 Drop upg_rstn_i mid-DATA after 2 bytes of word 3 -> all outputs 0 immediately; a following full load 01 00 AA BB CC DD -> adr 0 with 0xDDCCBBAA.
REQ-045 After done, send 5 more bytes -> no strobe, adr unchanged, done remains 1.
